retire_trace_monitor: RTL

Synthesizable retirement tracer for the 16-bit CPU. It turns per-cycle commit signals into classified, numbered trace records and buffers them in a DEPTH-entry FIFO for a valid/ready reader. It also keeps cycle and instruction counters, detects halt, and raises a watchdog timeout. It sits beside `cpu`, fed from its writeback/commit signals, and drives a trace reader (bench, UART dumper, or debug port).

---
 rtl/trace_pkg.sv | 42 ++++
 rtl/trace_fifo.sv | 45 ++++
 rtl/retire_trace_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retirement tracer: record kinds, the trace record
// layout and the monitor state encoding.
package trace_pkg;

   localparam int TR_DATA_W = 16;
   localparam int TR_REG_W  = 4;
   localparam int TR_CNT_W  = 32;

   typedef enum logic [2:0] {
      NOP   = 3'd0,
      REG   = 3'd1,
      LOAD  = 3'd2,
      STORE = 3'd3,
      HALT  = 3'd4
   } rec_kind_t;

   typedef struct packed {
      logic [TR_CNT_W-1:0]  inum;
      logic [TR_DATA_W-1:0] pc;
      rec_kind_t            kind;
      logic [TR_REG_W-1:0]  regIdx;
      logic [TR_DATA_W-1:0] value;
      logic [TR_DATA_W-1:0] addr;
   } trace_rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } mon_state_t;

   // Halt outranks everything; a load is a register write that also read memory.
   function automatic rec_kind_t classify(input logic regWrite, input logic memRead,
                                          input logic memWrite, input logic halt);
      if (halt)                 return HALT;
      if (regWrite && memRead)  return LOAD;
      if (regWrite)             return REG;
      if (memWrite)             return STORE;
      return NOP;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO of trace records; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  trace_rec_t               wrRec,
   output trace_rec_t               headRec,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   trace_rec_t     mem [DEPTH];
   logic [AW:0]    wrPtrReg;
   logic [AW:0]    rdPtrReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
      end else begin
         if (push) wrPtrReg <= wrPtrReg + (AW+1)'(1);
         if (pop)  rdPtrReg <= rdPtrReg + (AW+1)'(1);
      end
   end

   // Storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtrReg[AW-1:0]] <= wrRec;
   end

   assign headRec = mem[rdPtrReg[AW-1:0]];
   assign empty   = (wrPtrReg == rdPtrReg);
   assign full    = (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]) && (wrPtrReg[AW] != rdPtrReg[AW]);
   assign count   = wrPtrReg - rdPtrReg;

endmodule

// File: rtl/retire_trace_monitor.sv
// Turns per-cycle commit signals into numbered trace records, buffers them
// for a valid/ready reader, and tracks cycles, retires, drops, halt and watchdog.
module retire_trace_monitor
   import trace_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int DATA_W  = 16,
   parameter int REG_W   = 4,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ret_valid,
   input  logic [DATA_W-1:0] ret_pc,
   input  logic              ret_regwrite,
   input  logic              ret_memread,
   input  logic              ret_memwrite,
   input  logic              ret_halt,
   input  logic [REG_W-1:0]  ret_wreg,
   input  logic [DATA_W-1:0] ret_wdata,
   input  logic [DATA_W-1:0] ret_addr,
   input  logic [DATA_W-1:0] ret_mdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [CNT_W-1:0]  rd_inum,
   output logic [DATA_W-1:0] rd_pc,
   output logic [2:0]        rd_kind,
   output logic [REG_W-1:0]  rd_reg,
   output logic [DATA_W-1:0] rd_value,
   output logic [DATA_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              halted,
   output logic              timeout,
   output logic              overflow,
   output logic              done
);

   localparam int              PW      = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mon_state_t       stateReg, stateNext;
   logic [CNT_W-1:0] cycleReg, instReg, dropReg;
   logic             haltedReg, timeoutReg, overflowReg;

   trace_rec_t       wrRec, headRec;
   logic             full, empty, push, pop, capture, dropRec, timeoutHit, haltRetire;
   logic [PW-1:0]    fifoCount;

   assign capture    = ret_valid && (stateReg == RUN);
   assign haltRetire = capture && ret_halt;
   assign pop        = !empty && rd_ready;
   // A full FIFO still takes the record when the head leaves in the same edge.
   assign push       = capture && (!full || pop);
   assign dropRec    = capture && full && !pop;
   assign timeoutHit = (TIMEOUT != 0) && (cycleReg == CNT_W'(TIMEOUT));

   always_comb begin
      wrRec      = '0;
      wrRec.inum = TR_CNT_W'(instReg);
      wrRec.pc   = TR_DATA_W'(ret_pc);
      wrRec.kind = classify(ret_regwrite, ret_memread, ret_memwrite, ret_halt);
      unique case (wrRec.kind)
         LOAD: begin
            wrRec.regIdx = TR_REG_W'(ret_wreg);
            wrRec.value  = TR_DATA_W'(ret_wdata);
            wrRec.addr   = TR_DATA_W'(ret_addr);
         end
         REG: begin
            wrRec.regIdx = TR_REG_W'(ret_wreg);
            wrRec.value  = TR_DATA_W'(ret_wdata);
         end
         STORE: begin
            wrRec.value  = TR_DATA_W'(ret_mdata);
            wrRec.addr   = TR_DATA_W'(ret_addr);
         end
         default: ;
      endcase
   end

   trace_fifo #(.DEPTH(DEPTH)) fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wrRec   (wrRec),
      .headRec (headRec),
      .full    (full),
      .empty   (empty),
      .count   (fifoCount)
   );

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         RUN: begin
            if (haltRetire || timeoutHit) stateNext = DRAIN;
         end
         // Look ahead at the last pop so done follows it by exactly one cycle.
         DRAIN: begin
            if (empty || (pop && fifoCount == PW'(1))) stateNext = DONE;
         end
         default: stateNext = DONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg    <= RUN;
         cycleReg    <= '0;
         instReg     <= '0;
         dropReg     <= '0;
         haltedReg   <= 1'b0;
         timeoutReg  <= 1'b0;
         overflowReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == RUN) begin
            if (cycleReg != CNT_MAX) cycleReg <= cycleReg + CNT_W'(1);
            if (ret_valid && instReg != CNT_MAX) instReg <= instReg + CNT_W'(1);
            if (haltRetire)      haltedReg  <= 1'b1;
            else if (timeoutHit) timeoutReg <= 1'b1;
         end
         if (dropRec) begin
            overflowReg <= 1'b1;
            if (dropReg != CNT_MAX) dropReg <= dropReg + CNT_W'(1);
         end
      end
   end

   assign rd_valid    = !empty;
   assign rd_inum     = rd_valid ? CNT_W'(headRec.inum)    : '0;
   assign rd_pc       = rd_valid ? DATA_W'(headRec.pc)     : '0;
   assign rd_kind     = rd_valid ? headRec.kind            : 3'd0;
   assign rd_reg      = rd_valid ? REG_W'(headRec.regIdx)  : '0;
   assign rd_value    = rd_valid ? DATA_W'(headRec.value)  : '0;
   assign rd_addr     = rd_valid ? DATA_W'(headRec.addr)   : '0;
   assign cycle_count = cycleReg;
   assign inst_count  = instReg;
   assign drop_count  = dropReg;
   assign halted      = haltedReg;
   assign timeout     = timeoutReg;
   assign overflow    = overflowReg;
   assign done        = (stateReg == DONE);

endmodule
